wb_pipelined_ram_slave: RTL and testbench
=========================================

WB_PIPELINED_RAM_SLAVE -- requirements
Module: wb_pipelined_ram_slave

Interface
REQ-001 The block SHALL have parameter g_addr_width, default 32, Wishbone address width in bits.
REQ-002 The block SHALL have parameter g_data_width, default 32, data width; only 32 is supported, so sel is 4 bits.
REQ-003 The block SHALL have parameter g_size_words, default 256, memory depth in 32-bit words; it is a power of two, 2..65536.
REQ-004 The block SHALL have parameter g_ack_latency, default 1, cycles from request acceptance to ack/err; legal range 1..4.
REQ-005 The block SHALL have parameter g_stall_period, default 0, stall injection period; 0 = never stall, N>=2 = stall one cycle in every N.
REQ-006 The block SHALL have port clk_i, input, 1, the single clock.
REQ-007 The block SHALL have port rst_n_i, input, 1, reset that is asynchronous and active-low.
REQ-008 The block SHALL have port slave_i, input, t_wishbone_slave_in, carrying cyc, stb, we, sel(4), adr(g_addr_width) and dat(32) from the master.
REQ-009 The block SHALL have port slave_o, output, t_wishbone_slave_out, returning ack, err, rty, stall and dat(32) to the master.

Function
REQ-010 A request SHALL be accepted on a rising clk_i edge when cyc=1, stb=1 and stall=0; at most one request is accepted per cycle (Wishbone B4 pipelined).
REQ-011 Addressing SHALL be byte-granular: word index = adr[log2(g_size_words)+1:2], and adr[1:0] is ignored.
REQ-012 A request with adr >= 4*g_size_words SHALL be out of range.
REQ-013 An out-of-range request SHALL cause no memory write and SHALL receive err in place of ack.
REQ-014 An accepted in-range write SHALL update byte lane k (bits 8k+7:8k) only where sel[k]=1; sel=0000 is acked with no change.
REQ-015 An accepted in-range read SHALL capture the word at acceptance, and that value SHALL appear on dat in the same cycle as its ack.
REQ-016 An accepted write SHALL be visible to a read accepted in the following cycle (back-to-back write-then-read coherent).
REQ-017 Each accepted request SHALL produce exactly one single-cycle ack or err pulse, exactly g_ack_latency cycles after acceptance; responses are in order.
REQ-018 ack and err SHALL never be 1 in the same cycle.
REQ-019 ack/err SHALL be 1 only while cyc=1.
REQ-020 The response pipeline SHALL be a g_ack_latency-deep shift register of {valid, err, rdata}, which sustains one request per cycle with no throughput loss.
REQ-021 dat SHALL be 0 in every cycle without a read ack, including write acks and err cycles.
REQ-022 Stall injection SHALL use a free-running modulo-g_stall_period counter; stall=1 exactly when the counter equals g_stall_period-1, independent of cyc/stb.
REQ-023 When g_stall_period is 0 or 1, stall SHALL be held at 0.
REQ-024 When cyc deasserts with responses pending, all pending pipeline entries SHALL be flushed and no late ack/err emitted; writes already accepted remain in memory.
REQ-025 stb=1 with cyc=0 SHALL be ignored.
REQ-026 A new cycle SHALL be allowed to start the cycle after a flush.
REQ-027 rty SHALL be tied to 0.
REQ-028 An outstanding count SHALL be tracked internally for assertions; it never exceeds g_ack_latency.

Reset
REQ-029 While rst_n_i=0, ack, err, rty, stall and dat SHALL be 0, the response pipeline SHALL be emptied, and the stall counter SHALL be 0, all applied asynchronously.
REQ-030 Reset deassertion SHALL be sampled synchronously; the first request can be accepted on the first rising edge after rst_n_i rises.
REQ-031 Memory contents SHALL NOT be affected by reset; contents before the first write are undefined.
REQ-032 Reset asserted mid-cycle SHALL discard pending responses with no ack/err emitted.

Verification
REQ-033 Latency 1, no stall: write 0xDEADBEEF to adr 0x10 with sel=1111, then read adr 0x10 -> ack one cycle after each acceptance; read returns 0xDEADBEEF.
REQ-034 Byte enables: write 0x11223344 to 0x20 with sel=1111, then write 0xAABBCCDD to 0x20 with sel=0101 -> read of 0x20 returns 0x11BB33DD.
REQ-035 Latency 3, burst of 4 reads at 0x0, 0x4, 0x8, 0xC on consecutive cycles -> 4 acks on 4 consecutive cycles starting 3 cycles after the first acceptance, with data in order.
REQ-036 Out of range, g_size_words=256: write to 0x400, then read 0x0 -> write gets err and no ack; word 0 is unchanged.
REQ-037 g_stall_period=4, stb held high for 12 cycles -> stall high on 3 cycles, 9 requests accepted, 9 acks.
REQ-038 Latency 4: accept 2 requests, drop cyc after 2 cycles -> no ack/err emitted; a new cycle's read then acks normally; a mid-burst rst_n_i pulse yields all outputs 0 immediately.

Source files
------------

// File: rtl/wb_pipelined_ram_slave_if.sv
// Wishbone B4 pipelined slave bus: request bundle from the master, response bundle back.
// A single interface carries both directions so the slave binds to one modport.
interface wb_pipelined_ram_slave_if #(
   parameter int g_addr_width = 32,
   parameter int g_data_width = 32
);
   struct packed {
      logic                    cyc;
      logic                    stb;
      logic                    we;
      logic [3:0]              sel;
      logic [g_addr_width-1:0] adr;
      logic [g_data_width-1:0] dat;
   } slave_i;

   struct packed {
      logic                    ack;
      logic                    err;
      logic                    rty;
      logic                    stall;
      logic [g_data_width-1:0] dat;
   } slave_o;

   modport slave  (input slave_i, output slave_o);
   modport master (output slave_i, input slave_o);
endinterface

// File: rtl/wb_pipelined_ram_slave.sv
// Wishbone B4 pipelined RAM slave with fixed ack latency, byte lanes and periodic stall injection.
// Handshake: a request is taken on a rising edge with cyc=1, stb=1, stall=0; each one gets a single ack or err.
module wb_pipelined_ram_slave #(
   parameter int g_addr_width   = 32,
   parameter int g_data_width   = 32,
   parameter int g_size_words   = 256,
   parameter int g_ack_latency  = 1,
   parameter int g_stall_period = 0
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   wb_pipelined_ram_slave_if.slave  bus
);
   localparam int  IDX_W    = $clog2(g_size_words);
   localparam bit  STALL_EN = (g_stall_period >= 2);
   localparam int  CNT_W    = STALL_EN ? $clog2(g_stall_period) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = STALL_EN ? CNT_W'(g_stall_period - 1) : '0;

   logic [g_data_width-1:0] mem [g_size_words];

   logic                    cyc;
   logic                    stb;
   logic                    we;
   logic                    stall;
   logic                    accept;
   logic                    in_range;
   logic [IDX_W-1:0]        idx;
   logic [g_addr_width-1:0] adr_hi;
   logic [g_data_width-1:0] rdata_in;
   logic [CNT_W-1:0]        stall_cnt;

   logic [g_ack_latency-1:0] pipe_v;
   logic [g_ack_latency-1:0] pipe_e;
   logic [g_data_width-1:0]  pipe_d [g_ack_latency];
   logic [2:0]               outstanding;
   logic                     last_v;

   assign cyc      = bus.slave_i.cyc;
   assign stb      = bus.slave_i.stb;
   assign we       = bus.slave_i.we;
   assign idx      = bus.slave_i.adr[IDX_W+1:2];
   assign adr_hi   = bus.slave_i.adr >> (IDX_W + 2);
   assign in_range = (adr_hi == '0);
   assign accept   = cyc && stb && !stall;
   assign rdata_in = (!we && in_range) ? mem[idx] : '0;

   // Free-running regardless of bus activity, so stall cycles are predictable from reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stall_cnt <= '0;
      end else if (STALL_EN) begin
         stall_cnt <= (stall_cnt == CNT_LAST) ? '0 : stall_cnt + CNT_W'(1);
      end
   end

   assign stall = STALL_EN && (stall_cnt == CNT_LAST);

   always_ff @(posedge clk_i) begin
      if (accept && we && in_range) begin
         for (int k = 0; k < 4; k++) begin
            if (bus.slave_i.sel[k]) mem[idx][8*k +: 8] <= bus.slave_i.dat[8*k +: 8];
         end
      end
   end

   // Dropping cyc abandons the cycle: every in-flight response is discarded.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pipe_v <= '0;
         pipe_e <= '0;
         for (int i = 0; i < g_ack_latency; i++) pipe_d[i] <= '0;
      end else if (!cyc) begin
         pipe_v <= '0;
      end else begin
         pipe_v[0] <= accept;
         pipe_e[0] <= accept && !in_range;
         pipe_d[0] <= accept ? rdata_in : '0;
         for (int i = 1; i < g_ack_latency; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_e[i] <= pipe_e[i-1];
            pipe_d[i] <= pipe_d[i-1];
         end
      end
   end

   always_comb begin
      outstanding = '0;
      for (int i = 0; i < g_ack_latency; i++) outstanding = outstanding + 3'(pipe_v[i]);
   end

   always_comb begin
      bus.slave_o       = '0;
      last_v            = pipe_v[g_ack_latency-1] && cyc;
      bus.slave_o.ack   = last_v && !pipe_e[g_ack_latency-1];
      bus.slave_o.err   = last_v && pipe_e[g_ack_latency-1];
      bus.slave_o.rty   = 1'b0;
      bus.slave_o.stall = stall;
      bus.slave_o.dat   = (last_v && !pipe_e[g_ack_latency-1]) ? pipe_d[g_ack_latency-1] : '0;
   end

   a_outstanding: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      outstanding <= 3'(g_ack_latency));
   a_ack_err_excl: assert property (@(posedge clk_i)
      !(bus.slave_o.ack && bus.slave_o.err));
endmodule

// File: tb/tb_wb_pipelined_ram_slave.sv
// Self-checking bench: four slave configurations, vector table, hand sequences and a random run.
module tb_wb_pipelined_ram_slave;
   typedef struct packed {
      logic        cyc;
      logic        stb;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] adr;
      logic [31:0] dat;
   } req_t;

   typedef struct {
      logic        we;
      logic [3:0]  sel;
      logic [31:0] adr;
      logic [31:0] wdat;
      logic        ack;
      logic        err;
      logic [31:0] rdat;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst_d = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   edges;

   // clock / reset-relative edge counter
   always #5 clk = ~clk;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edges <= 0;
      else        edges <= edges + 1;
   end

   wb_pipelined_ram_slave_if #(.g_addr_width(32)) a_if ();
   wb_pipelined_ram_slave_if #(.g_addr_width(32)) b_if ();
   wb_pipelined_ram_slave_if #(.g_addr_width(32)) c_if ();
   wb_pipelined_ram_slave_if #(.g_addr_width(32)) d_if ();

   wb_pipelined_ram_slave #(.g_ack_latency(1), .g_stall_period(0)) dut_a (
      .clk_i(clk), .rst_n_i(rst_n), .bus(a_if.slave));
   wb_pipelined_ram_slave #(.g_ack_latency(3), .g_stall_period(0)) dut_b (
      .clk_i(clk), .rst_n_i(rst_n), .bus(b_if.slave));
   wb_pipelined_ram_slave #(.g_ack_latency(1), .g_stall_period(4)) dut_c (
      .clk_i(clk), .rst_n_i(rst_n), .bus(c_if.slave));
   wb_pipelined_ram_slave #(.g_ack_latency(4), .g_stall_period(0)) dut_d (
      .clk_i(clk), .rst_n_i(rst_d), .bus(d_if.slave));

   // driver helpers
   function automatic req_t mk_req(input logic cyc, stb, we, input logic [3:0] sel,
                                   input logic [31:0] adr, dat);
      req_t r;
      r.cyc = cyc; r.stb = stb; r.we = we; r.sel = sel; r.adr = adr; r.dat = dat;
      return r;
   endfunction

   function automatic logic [63:0] exp_resp(input logic ack, err, stall, input logic [31:0] dat);
      return {28'b0, ack, err, 1'b0, stall, dat};
   endfunction

   task automatic check(input string name, input logic [63:0] act, exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // scoreboard state for the random run: {due[31:0], err, known, dat[31:0]}
   logic [65:0] exp_q[$];
   logic [31:0] m_mem   [256];
   logic        m_known [256];
   vec_t        vecs    [16];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] act, e, mask;
      logic        cyc, stb, we, stall_exp, prev_acc, acc;
      logic [3:0]  sel;
      logic [31:0] adr, dat;
      int          w, cyc_no, stalls, acks;
      logic [65:0] ent;

      vecs[0]  = '{1'b1, 4'hF, 32'h10,       32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
      vecs[1]  = '{1'b0, 4'hF, 32'h10,       32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
      vecs[2]  = '{1'b1, 4'hF, 32'h20,       32'h11223344, 1'b1, 1'b0, 32'h0};
      vecs[3]  = '{1'b1, 4'h5, 32'h20,       32'hAABBCCDD, 1'b1, 1'b0, 32'h0};
      vecs[4]  = '{1'b0, 4'hF, 32'h20,       32'h0,        1'b1, 1'b0, 32'h11BB33DD};
      vecs[5]  = '{1'b1, 4'hF, 32'h0,        32'hCAFEF00D, 1'b1, 1'b0, 32'h0};
      vecs[6]  = '{1'b1, 4'hF, 32'h400,      32'h12345678, 1'b0, 1'b1, 32'h0};
      vecs[7]  = '{1'b0, 4'hF, 32'h0,        32'h0,        1'b1, 1'b0, 32'hCAFEF00D};
      vecs[8]  = '{1'b1, 4'hF, 32'h3FC,      32'h0BADC0DE, 1'b1, 1'b0, 32'h0};
      vecs[9]  = '{1'b0, 4'hF, 32'h3FF,      32'h0,        1'b1, 1'b0, 32'h0BADC0DE};
      vecs[10] = '{1'b0, 4'hF, 32'h400,      32'h0,        1'b0, 1'b1, 32'h0};
      vecs[11] = '{1'b1, 4'h0, 32'h20,       32'hFFFFFFFF, 1'b1, 1'b0, 32'h0};
      vecs[12] = '{1'b0, 4'hF, 32'h22,       32'h0,        1'b1, 1'b0, 32'h11BB33DD};
      vecs[13] = '{1'b0, 4'hF, 32'hFFFFFFFC, 32'h0,        1'b0, 1'b1, 32'h0};
      vecs[14] = '{1'b1, 4'h8, 32'h10,       32'h55000000, 1'b1, 1'b0, 32'h0};
      vecs[15] = '{1'b0, 4'hF, 32'h11,       32'h0,        1'b1, 1'b0, 32'h55ADBEEF};

      a_if.slave_i = mk_req(1'b1, 1'b1, 1'b1, 4'hF, 32'h10, 32'h1);
      b_if.slave_i = '0;
      c_if.slave_i = '0;
      d_if.slave_i = mk_req(1'b1, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0);

      // reset: outputs quiet even with a request presented
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         check($sformatf("reset_a_%0d", i), 64'(a_if.slave_o), exp_resp(0, 0, 0, 0));
         check($sformatf("reset_d_%0d", i), 64'(d_if.slave_o), exp_resp(0, 0, 0, 0));
      end
      @(negedge clk);
      a_if.slave_i = '0;
      d_if.slave_i = '0;
      rst_n = 1'b1;
      rst_d = 1'b1;

      // vector table on the latency-1 slave
      for (int v = 0; v < 16; v++) begin
         a_if.slave_i = mk_req(1'b1, 1'b1, vecs[v].we, vecs[v].sel, vecs[v].adr, vecs[v].wdat);
         #1;
         check($sformatf("vec%0d_req_cycle", v), 64'(a_if.slave_o), exp_resp(0, 0, 0, 0));
         @(negedge clk);
         a_if.slave_i = mk_req(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
         #1;
         check($sformatf("vec%0d_resp", v), 64'(a_if.slave_o),
               exp_resp(vecs[v].ack, vecs[v].err, 0, vecs[v].rdat));
         @(negedge clk);
      end

      // latency 3: four writes then four back-to-back reads
      for (int c = 0; c < 13; c++) begin
         if (c < 4)      b_if.slave_i = mk_req(1, 1, 1, 4'hF, 32'(c * 4), 32'hB0000000 + 32'(c));
         else if (c < 8) b_if.slave_i = mk_req(1, 1, 0, 4'hF, 32'((c - 4) * 4), 32'h0);
         else            b_if.slave_i = mk_req(1, 0, 0, 4'h0, 32'h0, 32'h0);
         #1;
         w = c - 3;
         if (w >= 4 && w < 8) e = exp_resp(1, 0, 0, 32'hB0000000 + 32'(w - 4));
         else if (w >= 0 && w < 4) e = exp_resp(1, 0, 0, 32'h0);
         else e = exp_resp(0, 0, 0, 32'h0);
         check($sformatf("lat3_c%0d", c), 64'(b_if.slave_o), e);
         @(negedge clk);
      end
      b_if.slave_i = '0;

      // stall period 4: stb held for 12 cycles
      stalls = 0; acks = 0; prev_acc = 1'b0;
      for (int c = 0; c < 14; c++) begin
         c_if.slave_i = mk_req(1, c < 12, 1, 4'hF, 32'(c * 4), 32'(c));
         #1;
         stall_exp = ((edges % 4) == 3);
         check($sformatf("stall_c%0d", c), 64'(c_if.slave_o), exp_resp(prev_acc, 0, stall_exp, 0));
         if (c < 12 && c_if.slave_o.stall) stalls++;
         if (c_if.slave_o.ack) acks++;
         prev_acc = (c < 12) && !stall_exp;
         @(negedge clk);
      end
      c_if.slave_i = '0;
      check("stall_count", 64'(stalls), 64'd3);
      check("stall_acks", 64'(acks), 64'd9);

      // latency 4: drop cyc with two requests in flight, then a fresh cycle
      for (int c = 0; c < 11; c++) begin
         case (c)
            0:       d_if.slave_i = mk_req(1, 1, 1, 4'hF, 32'h8, 32'hD00D0008);
            1:       d_if.slave_i = mk_req(1, 1, 1, 4'hF, 32'hC, 32'hD00D000C);
            2:       d_if.slave_i = mk_req(0, 1, 1, 4'hF, 32'h8, 32'h0);
            3:       d_if.slave_i = mk_req(1, 1, 0, 4'hF, 32'h8, 32'h0);
            4:       d_if.slave_i = mk_req(1, 1, 0, 4'hF, 32'hC, 32'h0);
            default: d_if.slave_i = mk_req(1, 0, 0, 4'h0, 32'h0, 32'h0);
         endcase
         #1;
         if (c == 7)      e = exp_resp(1, 0, 0, 32'hD00D0008);
         else if (c == 8) e = exp_resp(1, 0, 0, 32'hD00D000C);
         else             e = exp_resp(0, 0, 0, 32'h0);
         check($sformatf("flush_c%0d", c), 64'(d_if.slave_o), e);
         @(negedge clk);
      end

      // latency 4: reset pulse with reads in flight
      for (int c = 0; c < 4; c++) begin
         d_if.slave_i = mk_req(1, 1, 0, 4'hF, 32'h8, 32'h0);
         @(negedge clk);
      end
      d_if.slave_i = mk_req(1, 0, 0, 4'h0, 32'h0, 32'h0);
      #1;
      check("pre_reset_ack", 64'(d_if.slave_o), exp_resp(1, 0, 0, 32'hD00D0008));
      rst_d = 1'b0;
      #1;
      check("reset_async", 64'(d_if.slave_o), exp_resp(0, 0, 0, 32'h0));
      @(negedge clk);
      #1;
      check("reset_held", 64'(d_if.slave_o), exp_resp(0, 0, 0, 32'h0));
      rst_d = 1'b1;
      for (int c = 0; c < 7; c++) begin
         if (c == 1) d_if.slave_i = mk_req(1, 1, 0, 4'hF, 32'hC, 32'h0);
         else        d_if.slave_i = mk_req(1, 0, 0, 4'h0, 32'h0, 32'h0);
         #1;
         e = (c == 5) ? exp_resp(1, 0, 0, 32'hD00D000C) : exp_resp(0, 0, 0, 32'h0);
         check($sformatf("post_reset_c%0d", c), 64'(d_if.slave_o), e);
         @(negedge clk);
      end
      d_if.slave_i = '0;

      // random traffic on the latency-1 slave against a word-array model
      for (int i = 0; i < 256; i++) begin
         m_mem[i] = '0;
         m_known[i] = 1'b0;
      end
      exp_q.delete();
      cyc_no = 0;
      for (int n = 0; n < 500; n++) begin
         cyc = ($urandom_range(0, 15) != 0);
         stb = ($urandom_range(0, 3) != 0);
         we  = 1'($urandom_range(0, 1));
         sel = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 9) == 0) adr = 32'h400 + 32'($urandom_range(0, 65535));
         else adr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
         dat = $urandom;
         a_if.slave_i = mk_req(cyc, stb, we, sel, adr, dat);
         #1;
         if (!cyc) exp_q.delete();
         e = exp_resp(0, 0, 0, 32'h0);
         mask = {64{1'b1}};
         if (exp_q.size() > 0 && int'(exp_q[0][65:34]) == cyc_no) begin
            ent = exp_q.pop_front();
            e = exp_resp(!ent[33], ent[33], 0, ent[31:0]);
            if (!ent[32]) mask = {32'hFFFFFFFF, 32'h0};
         end
         act = 64'(a_if.slave_o);
         check($sformatf("rand_%0d", n), act & mask, e & mask);
         acc = cyc && stb;
         if (acc) begin
            w = int'(adr >> 2);
            if (adr >= 32'h400) begin
               exp_q.push_back({32'(cyc_no + 1), 1'b1, 1'b1, 32'h0});
            end else if (!we) begin
               exp_q.push_back({32'(cyc_no + 1), 1'b0, m_known[w], m_mem[w]});
            end else begin
               exp_q.push_back({32'(cyc_no + 1), 1'b0, 1'b1, 32'h0});
               for (int k = 0; k < 4; k++)
                  if (sel[k]) m_mem[w][8*k +: 8] = dat[8*k +: 8];
               if (sel == 4'hF) m_known[w] = 1'b1;
            end
         end
         cyc_no++;
         @(negedge clk);
      end
      a_if.slave_i = '0;

      // final report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
